// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - two-road signal controller, optional pedestrian phase under TRAFFIC_PED_EN
module traffic_intersection_ctrl #(
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 6,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Timer reload values: a state of duration D counts D-1 down to 0
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_next;
  logic [2:0]       ns_next;
  logic [2:0]       ew_next;

`ifdef TRAFFIC_PED_EN
  localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(WALK_T - 1);
  logic ped_pending;
  logic ped_next;
  logic walk_r;
`endif

  // Sequencing: hold each state until the timer hits 0, then step and reload
  always_comb begin
    state_next = state;
    timer_next = timer - CNT_W'(1);
    case (state)
      NS_GREEN: begin
        if (timer == '0) begin
          state_next = NS_YELLOW;
          timer_next = YELLOW_LD;
        end
      end
      NS_YELLOW: begin
        if (timer == '0) begin
          state_next = ALLRED_A;
          timer_next = ALLRED_LD;
        end
      end
      ALLRED_A: begin
        if (timer == '0) begin
          state_next = EW_GREEN;
          timer_next = GREEN_LD;
        end
      end
      EW_GREEN: begin
        if (timer == '0) begin
          state_next = EW_YELLOW;
          timer_next = YELLOW_LD;
        end
      end
      EW_YELLOW: begin
        if (timer == '0) begin
          state_next = ALLRED_B;
          timer_next = ALLRED_LD;
        end
      end
      ALLRED_B: begin
        if (timer == '0) begin
          state_next = NS_GREEN;
          timer_next = GREEN_LD;
`ifdef TRAFFIC_PED_EN
          if (ped_pending) begin
            state_next = PED_WALK;
            timer_next = WALK_LD;
          end
`endif
        end
      end
`ifdef TRAFFIC_PED_EN
      PED_WALK: begin
        if (timer == '0) begin
          state_next = NS_GREEN;
          timer_next = GREEN_LD;
        end
      end
`endif
      default: begin
        // Unknown code: park in the clearance state before resuming the ring
        state_next = ALLRED_B;
        timer_next = ALLRED_LD;
      end
    endcase
  end

  // Lamp decode of the upcoming state so lamps register on the state edge
  always_comb begin
    ns_next = LAMP_RED;
    ew_next = LAMP_RED;
    case (state_next)
      NS_GREEN:  ns_next = LAMP_GRN;
      NS_YELLOW: ns_next = LAMP_YEL;
      EW_GREEN:  ew_next = LAMP_GRN;
      EW_YELLOW: ew_next = LAMP_YEL;
      default: begin
        ns_next = LAMP_RED;
        ew_next = LAMP_RED;
      end
    endcase
  end

  // State, timer and lamp registers; reset parks the junction in all-red
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ALLRED_B;
      timer    <= ALLRED_LD;
      ns_light <= LAMP_RED;
      ew_light <= LAMP_RED;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      ns_light <= ns_next;
      ew_light <= ew_next;
    end
  end

  assign phase = state;

`ifdef TRAFFIC_PED_EN
  // Remember a request until the walk starts; requests on that edge or during the walk are dropped
  always_comb begin
    ped_next = ped_pending;
    if (state_next == PED_WALK && state != PED_WALK) begin
      ped_next = 1'b0;
    end else if (ped_req && state != PED_WALK) begin
      ped_next = 1'b1;
    end
  end

  // Pending flag and walk lamp registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pending <= 1'b0;
      walk_r      <= 1'b0;
    end else begin
      ped_pending <= ped_next;
      walk_r      <= (state_next == PED_WALK);
    end
  end

  assign walk = walk_r;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign walk           = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb/tb_traffic_intersection_ctrl.sv - randomized bench for traffic_intersection_ctrl against a phase-schedule model
module tb_traffic_intersection_ctrl;

  localparam int GREEN_T  = 8;
  localparam int YELLOW_T = 3;
  localparam int ALLRED_T = 2;
  localparam int WALK_T   = 6;
`ifdef TRAFFIC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       ped_req;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk;
  logic       ped_req2;
  logic [2:0] ns2, ew2, phase2;
  logic       walk2;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: current phase, cycles left in it, pending request
  int m_phase;
  int m_left;
  bit m_pend;

  traffic_intersection_ctrl dut (
    .clk(clk), .reset(reset), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .phase(phase)
  );

  traffic_intersection_ctrl #(.GREEN_T(1), .YELLOW_T(1), .ALLRED_T(1)) dut_fast (
    .clk(clk), .reset(reset), .ped_req(ped_req2),
    .ns_light(ns2), .ew_light(ew2), .walk(walk2), .phase(phase2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur_of(input int p);
    case (p)
      0, 3:    return GREEN_T;
      1, 4:    return YELLOW_T;
      2, 5:    return ALLRED_T;
      default: return WALK_T;
    endcase
  endfunction

  function automatic int after(input int p, input bit pend);
    if (p == 5) return (PED_EN && pend) ? 6 : 0;
    if (p == 6) return 0;
    return p + 1;
  endfunction

  task automatic model_reset();
    m_phase = 5;
    m_left  = ALLRED_T;
    m_pend  = 1'b0;
  endtask

  // One rising edge of the model, given the ped_req seen at that edge
  task automatic model_step(input bit req);
    int  old;
    bit  entered_walk;
    old = m_phase;
    entered_walk = 1'b0;
    if (m_left == 1) begin
      m_phase = after(old, m_pend);
      m_left  = dur_of(m_phase);
      if (m_phase == 6 && old != 6) begin
        entered_walk = 1'b1;
        m_pend = 1'b0;
      end
    end else begin
      m_left--;
    end
    if (PED_EN && req && old != 6 && !entered_walk) m_pend = 1'b1;
  endtask

  task automatic check_outputs();
    logic [2:0] ens, eew;
    ens = (m_phase == 0) ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
    eew = (m_phase == 3) ? 3'b001 : (m_phase == 4) ? 3'b010 : 3'b100;
    check("ns_light", 32'(ns_light), 32'(ens));
    check("ew_light", 32'(ew_light), 32'(eew));
    check("walk", 32'(walk), 32'(m_phase == 6));
    check("phase", 32'(phase), 32'(m_phase));
    check("mutex", 32'(ns_light == 3'b100 || ew_light == 3'b100), 32'd1);
  endtask

  // Called at a negedge: check, drive the next request, advance the model to the next negedge
  task automatic run_cycle(input bit req);
    check_outputs();
    ped_req = req;
    model_step(req);
    @(negedge clk);
  endtask

  initial begin
    bit found;
    reset    = 1'b0;
    ped_req  = 1'b0;
    ped_req2 = 1'b0;
    #1 reset = 1'b1;
    #2;
    // Asynchronous reset values before any clock edge
    check("rst_ns", 32'(ns_light), 32'h4);
    check("rst_ew", 32'(ew_light), 32'h4);
    check("rst_walk", 32'(walk), 32'h0);
    check("rst_phase", 32'(phase), 32'd5);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Quiet run; the fast instance must cycle 5,0,1,2,3,4 with one cycle each
    for (int n = 0; n < 60; n++) begin
      check("fast_phase", 32'(phase2), 32'((n + 5) % 6));
      check("fast_mutex", 32'(ns2 == 3'b100 || ew2 == 3'b100), 32'd1);
      run_cycle(1'b0);
    end

    // Sparse random requests, occasionally in bursts
    for (int n = 0; n < 250; n++) begin
      run_cycle($urandom_range(0, 11) == 0);
    end

    // Reach mid NS_GREEN with a request pending, then reset asynchronously
    found = 1'b0;
    for (int n = 0; n < 120 && !found; n++) begin
      if (m_phase == 0 && m_left < GREEN_T - 1 && (m_pend || !PED_EN)) found = 1'b1;
      else run_cycle(m_phase == 0);
    end
    check("mid_wait", 32'(found), 32'd1);
    ped_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_ns", 32'(ns_light), 32'h4);
    check("mid_ew", 32'(ew_light), 32'h4);
    check("mid_phase", 32'(phase), 32'd5);
    check("mid_walk", 32'(walk), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 60; n++) run_cycle(1'b0);

    // Request held high continuously
    for (int n = 0; n < 90; n++) run_cycle(1'b1);

    // More random traffic with dense requests
    for (int n = 0; n < 150; n++) run_cycle($urandom_range(0, 2) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 The block SHALL have parameter GREEN_T, default 8, green duration in clock cycles per road.
REQ-002 The block SHALL have parameter YELLOW_T, default 3, yellow duration in cycles.
REQ-003 The block SHALL have parameter ALLRED_T, default 2, all-red clearance duration in cycles.
REQ-004 The block SHALL have parameter WALK_T, default 6, pedestrian walk duration in cycles.
REQ-005 The block SHALL have parameter CNT_W, default 8, phase-timer width; each duration SHALL be in the range 1 to 2^CNT_W-1.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port ped_req, input, 1 bit: pedestrian request, sampled each cycle, any pulse width.
REQ-009 The block SHALL have port ns_light, output, 3 bits: north-south lamps, one-hot, {red,yellow,green} = bits [2:0].
REQ-010 The block SHALL have port ew_light, output, 3 bits: east-west lamps, same encoding as ns_light.
REQ-011 The block SHALL have port walk, output, 1 bit: pedestrian walk lamp.
REQ-012 The block SHALL have port phase, output, 3 bits: current state code.

Function
REQ-013 States and codes SHALL be: NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, PED_WALK=6.
REQ-014 Each state SHALL last exactly its duration: GREEN_T for greens, YELLOW_T for yellows, ALLRED_T for ALLRED_A/B, WALK_T for PED_WALK.
REQ-015 The down-counting timer SHALL be loaded with duration-1 on state entry; the state SHALL advance on the edge at which the timer reads 0.
REQ-016 Transitions SHALL be: NS_GREEN->NS_YELLOW->ALLRED_A->EW_GREEN->EW_YELLOW->ALLRED_B->(PED_WALK if ped_pending, else NS_GREEN); PED_WALK->NS_GREEN.
REQ-017 Lamps SHALL be: NS_GREEN ns=001 ew=100; NS_YELLOW ns=010 ew=100; EW_GREEN ns=100 ew=001; EW_YELLOW ns=100 ew=010; ALLRED_A/B and PED_WALK ns=ew=100.
REQ-018 walk SHALL be 1 only in PED_WALK.
REQ-019 All outputs SHALL be registered and SHALL change on the same edge as the state change; no combinational path from ped_req to any output.
REQ-020 At no time SHALL ns_light and ew_light both differ from 100.
REQ-021 ped_pending SHALL be set on any cycle with ped_req=1, outside PED_WALK and outside the ALLRED_B->PED_WALK transition edge.
REQ-022 ped_pending SHALL be cleared on the edge entering PED_WALK; a ped_req coincident with that edge or during PED_WALK SHALL be discarded.
REQ-023 Repeated ped_req pulses before service SHALL produce exactly one PED_WALK.
REQ-024 An illegal state code SHALL recover to ALLRED_B with the timer loaded to ALLRED_T-1.

Reset
REQ-025 While reset=1, asynchronously: state=ALLRED_B, timer=ALLRED_T-1, ped_pending=0, ns_light=ew_light=100, walk=0, phase=5.
REQ-026 After reset deasserts, the block SHALL show ALLRED_T cycles of all-red, then enter NS_GREEN, or PED_WALK if ped_req was seen in that window.
REQ-027 Reset asserted mid-phase SHALL abort the phase immediately and discard any pending pedestrian request.

Configuration
REQ-028 Macro TRAFFIC_PED_EN SHALL compile in the PED_WALK state, ped_pending and the walk logic.
REQ-029 Without TRAFFIC_PED_EN: ped_req SHALL be ignored, walk SHALL be tied to 0, and ALLRED_B SHALL always go to NS_GREEN; ports SHALL be unchanged.

Verification
REQ-030 Defaults, no ped_req: reset for 2 cycles, then release -> 2 all-red cycles, then repeating 26-cycle period: ns 001 x8, 010 x3, all-red x2, ew 001 x8, 010 x3, all-red x2.
REQ-031 TRAFFIC_PED_EN, 1-cycle ped_req during EW_GREEN -> after ALLRED_B, 6 cycles walk=1 with ns=ew=100 and phase=6, then NS_GREEN; the next cycle has no walk.
REQ-032 TRAFFIC_PED_EN, three ped_req pulses within one period -> exactly one PED_WALK of 6 cycles.
REQ-033 reset asserted for 1 cycle mid-NS_GREEN with ped_pending=1 -> outputs 100/100 immediately, phase=5; no PED_WALK follows.
REQ-034 GREEN_T=1, YELLOW_T=1, ALLRED_T=1 -> 6-cycle period; every cycle passes the REQ-020 mutual-exclusion check.
REQ-035 Without TRAFFIC_PED_EN, ped_req held at 1 continuously -> walk stays 0 and the 26-cycle period is unchanged.
